frame_sync_ctrl: RTL and testbench
==================================

// Module: frame_sync_ctrl
// PURPOSE
//  Frame-synchronisation controller that sequences the serial pattern detector in the equaliser RX path.
//  Each qualified serial bit is shifted into a PAT_W-bit window and compared with a fixed sync PATTERN.
//  A HUNT/VERIFY/LOCKED FSM uses those matches to acquire frame alignment and hold it with flywheel tolerance.
//  Outputs lock status and a frame-start strobe that downstream equaliser blocks use to align coefficient updates.
// PARAMETERS
//  PAT_W        3       sync pattern width in bits, >=2
//  PATTERN      3'b101  sync word; the first-received bit is the MSB
//  FRAME_LEN    8       bits per frame, measured from one pattern end to the next; must be >= PAT_W
//  LOCK_HITS    3       consecutive aligned matches needed to lock, counting the HUNT match; must be >= 2
//  LOSS_MISSES  2       consecutive missed checks in LOCKED that drop lock; must be >= 1
// PORTS
//  clk          in   1                  system clock, rising edge
//  rst          in   1                  synchronous reset, active-high
//  x            in   1                  serial data bit
//  bit_valid    in   1                  x is valid this cycle; all state advances only when this is 1
//  locked       out  1                  1 while the FSM is in LOCKED
//  frame_start  out  1                  1-cycle pulse at each frame boundary while LOCKED
//  pat_hit      out  1                  registered: a valid bit completed PATTERN on the previous cycle
//  state        out  2                  FSM state: 00 HUNT, 01 VERIFY, 10 LOCKED
//  bit_pos      out  clog2(FRAME_LEN)   position within the frame, 0..FRAME_LEN-1
// BEHAVIOUR
//  - Reset: synchronous, active-high; rst wins over bit_valid. Every register and output goes to 0, state goes to HUNT.
//  - Window: on bit_valid, sr <= {sr[PAT_W-2:0], x}.
//  - Match: match = bit_valid & ({sr[PAT_W-2:0], x} == PATTERN). The current bit is included, so a match costs no extra cycle.
//  - Check bit: a valid bit with bit_pos == FRAME_LEN-1.
//  - bit_pos in VERIFY/LOCKED: on each valid bit, wraps FRAME_LEN-1 -> 0, otherwise increments. It holds when bit_valid=0.
//  - bit_pos in HUNT: held at 0.
//  - HUNT: on match -> VERIFY, with hit_cnt <= 1 and bit_pos <= 0. Otherwise stay in HUNT.
//  - VERIFY, check bit with match: hit_cnt <= hit_cnt+1. If hit_cnt+1 == LOCK_HITS -> LOCKED, with miss_cnt <= 0.
//  - VERIFY, check bit without match: -> HUNT. A match on a non-check bit is ignored.
//  - LOCKED, every check bit: frame_start pulses on the next cycle, whether or not the check bit matched (flywheel).
//  - LOCKED, check bit with match: miss_cnt <= 0.
//  - LOCKED, check bit without match: miss_cnt <= miss_cnt+1. If miss_cnt+1 == LOSS_MISSES -> HUNT; locked falls on the next cycle.
//  - Matches on non-check bits never affect VERIFY or LOCKED.
//  - Output timing: locked, frame_start, pat_hit and state are registered. They update 1 cycle after the deciding bit.
//  - Overlap: the window is never cleared by a match, so overlapping patterns (e.g. 10101) are detected.
//  - Counter widths: hit_cnt = clog2(LOCK_HITS+1) bits, miss_cnt = clog2(LOSS_MISSES+1) bits. Neither can exceed its threshold.
//  - Illegal state 11 -> HUNT on the next cycle, with counters cleared.
// CONFIGURATION
//  FRAME_SYNC_STATS_EN defined:
//   - Adds ports hit_count[15:0] and miss_count[15:0] (outputs).
//   - hit_count counts aligned check-bit matches; miss_count counts missed check bits in VERIFY/LOCKED.
//   - Both saturate at 16'hFFFF and are cleared only by rst.
//  FRAME_SYNC_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING (defaults; frame = 101 followed by 00000, i.e. 10100000 repeating)
//  1. rst=1 for 2 cycles, bit_valid=1, x=1 -> state=00, locked=0, frame_start=0, pat_hit=0, bit_pos=0.
//  2. 3 aligned frames -> pat_hit=1 after each 101; state=01 after frame 1; locked=1 one cycle after the 3rd pattern end.
//  3. When locked, corrupt 1 frame's 101 into 001 -> locked stays 1, frame_start still pulses. Corrupt the next frame too -> locked=0, state=00.
//  4. In VERIFY, place 101 ending at bit_pos=4 and 000 at the check bit -> pat_hit=1 at pos 4, then state=00 after the check bit.
//  5. When locked, hold bit_valid=0 for 5 cycles mid-frame -> bit_pos, state and outputs frozen; resume -> frame_start stays on schedule.
//  6. Assert rst for 1 cycle while LOCKED at bit_pos=6 -> next cycle all outputs 0, state=00; with STATS_EN, counters also read 0.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// Frame-sync controller: sliding pattern window plus HUNT/VERIFY/LOCKED alignment FSM with flywheel.
// Optional FRAME_SYNC_STATS_EN adds saturating hit_count/miss_count statistics outputs.
module frame_sync_ctrl #(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] PATTERN     = 3'b101,
    parameter int               FRAME_LEN   = 8,
    parameter int               LOCK_HITS   = 3,
    parameter int               LOSS_MISSES = 2,
    localparam int              POS_W       = $clog2(FRAME_LEN),
    localparam int              HIT_W       = $clog2(LOCK_HITS + 1),
    localparam int              MISS_W      = $clog2(LOSS_MISSES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             bit_valid,
    output logic             locked,
    output logic             frame_start,
    output logic             pat_hit,
    output logic [1:0]       state,
    output logic [POS_W-1:0] bit_pos
`ifdef FRAME_SYNC_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        VERIFY  = 2'b01,
        LOCKED  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [PAT_W-2:0]   sr_reg, sr_next;
    logic [HIT_W-1:0]   hit_cnt_reg, hit_cnt_next;
    logic [MISS_W-1:0]  miss_cnt_reg, miss_cnt_next;
    logic [POS_W-1:0]   bit_pos_reg, bit_pos_next;
    logic               locked_reg, frame_start_reg, frame_start_next, pat_hit_reg;

    logic [PAT_W-1:0]   window;
    logic               match;
    logic               check;
    logic [POS_W-1:0]   pos_inc;

    // The incoming bit is part of the compared window, so a match is seen on the bit that completes it.
    assign window  = {sr_reg, x};
    assign match   = bit_valid && (window == PATTERN);
    assign check   = bit_valid && (bit_pos_reg == POS_W'(FRAME_LEN - 1));
    assign pos_inc = (bit_pos_reg == POS_W'(FRAME_LEN - 1)) ? '0 : bit_pos_reg + POS_W'(1);

    always_comb begin
        state_next       = state_reg;
        sr_next          = bit_valid ? window[PAT_W-2:0] : sr_reg;
        hit_cnt_next     = hit_cnt_reg;
        miss_cnt_next    = miss_cnt_reg;
        bit_pos_next     = bit_pos_reg;
        frame_start_next = 1'b0;
        case (state_reg)
            HUNT: begin
                bit_pos_next = '0;
                if (match) begin
                    state_next   = VERIFY;
                    hit_cnt_next = HIT_W'(1);
                end
            end
            VERIFY: begin
                if (bit_valid) bit_pos_next = pos_inc;
                if (check) begin
                    if (match) begin
                        hit_cnt_next = hit_cnt_reg + HIT_W'(1);
                        if (hit_cnt_reg + HIT_W'(1) == HIT_W'(LOCK_HITS)) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else begin
                        state_next   = HUNT;
                        hit_cnt_next = '0;
                        bit_pos_next = '0;
                    end
                end
            end
            LOCKED: begin
                if (bit_valid) bit_pos_next = pos_inc;
                if (check) begin
                    // Flywheel: the frame boundary is signalled even when the sync word was missed.
                    frame_start_next = 1'b1;
                    if (match) begin
                        miss_cnt_next = '0;
                    end else if (miss_cnt_reg + MISS_W'(1) == MISS_W'(LOSS_MISSES)) begin
                        state_next    = HUNT;
                        miss_cnt_next = '0;
                        hit_cnt_next  = '0;
                        bit_pos_next  = '0;
                    end else begin
                        miss_cnt_next = miss_cnt_reg + MISS_W'(1);
                    end
                end
            end
            default: begin
                state_next    = HUNT;
                hit_cnt_next  = '0;
                miss_cnt_next = '0;
                bit_pos_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= HUNT;
            sr_reg          <= '0;
            hit_cnt_reg     <= '0;
            miss_cnt_reg    <= '0;
            bit_pos_reg     <= '0;
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            pat_hit_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sr_reg          <= sr_next;
            hit_cnt_reg     <= hit_cnt_next;
            miss_cnt_reg    <= miss_cnt_next;
            bit_pos_reg     <= bit_pos_next;
            locked_reg      <= (state_next == LOCKED);
            frame_start_reg <= frame_start_next;
            pat_hit_reg     <= match;
        end
    end

    assign locked      = locked_reg;
    assign frame_start = frame_start_reg;
    assign pat_hit     = pat_hit_reg;
    assign state       = state_reg;
    assign bit_pos     = bit_pos_reg;

`ifdef FRAME_SYNC_STATS_EN
    logic        in_sync;
    logic        hit_ev, miss_ev;
    logic [15:0] hit_count_reg, miss_count_reg;

    assign in_sync = (state_reg == VERIFY) || (state_reg == LOCKED);
    assign hit_ev  = in_sync && check && match;
    assign miss_ev = in_sync && check && !match;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_ev && hit_count_reg != 16'hFFFF)   hit_count_reg  <= hit_count_reg + 16'd1;
            if (miss_ev && miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl at default parameters; frame = 10100000 repeating.
// Compares {state, locked, frame_start, pat_hit, bit_pos} after each deciding bit.
module tb_frame_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       bit_valid = 1'b0;
    logic       locked, frame_start, pat_hit;
    logic [1:0] state;
    logic [2:0] bit_pos;
`ifdef FRAME_SYNC_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    frame_sync_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .bit_valid  (bit_valid),
        .locked     (locked),
        .frame_start(frame_start),
        .pat_hit    (pat_hit),
        .state      (state),
        .bit_pos    (bit_pos)
`ifdef FRAME_SYNC_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        $display("check %-16s observed=%b expected=%b", tag, obs, exp_v);
    endtask

    function automatic logic [15:0] pk(input logic [1:0] st, input logic lk, input logic fs,
                                       input logic ph, input logic [2:0] pos);
        return {8'h00, st, lk, fs, ph, pos};
    endfunction

    function automatic logic [15:0] obs_v();
        return {8'h00, state, locked, frame_start, pat_hit, bit_pos};
    endfunction

    task automatic step(input logic b, input logic v);
        @(negedge clk);
        rst       = 1'b0;
        x         = b;
        bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
    endtask

    initial begin
        // 1. reset with bit_valid and x high
        rst = 1'b1; bit_valid = 1'b1; x = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs_v(), pk(2'b00, 0, 0, 0, 3'd0));

        // 2. three aligned frames to lock
        step(1, 1);           chk("hunt_b0",     obs_v(), pk(2'b00, 0, 0, 0, 3'd0));
        step(0, 1); step(1, 1); chk("hunt_match", obs_v(), pk(2'b01, 0, 0, 1, 3'd0));
        step(0, 1);           chk("verify_pos1", obs_v(), pk(2'b01, 0, 0, 0, 3'd1));
        send(8'b0000_0000, 4); chk("frame1_end",  obs_v(), pk(2'b01, 0, 0, 0, 3'd5));
        send(8'b0000_0010, 2); step(1, 1);
        chk("f2_check", obs_v(), pk(2'b01, 0, 0, 1, 3'd0));
        send(8'b0000_0000, 5);
        send(8'b0000_0010, 2); step(1, 1);
        chk("lock", obs_v(), pk(2'b10, 1, 0, 1, 3'd0));
        send(8'b0000_0000, 5);
        send(8'b0000_0010, 2); step(1, 1);
        chk("fs_locked", obs_v(), pk(2'b10, 1, 1, 1, 3'd0));
        step(0, 1);           chk("fs_pulse_end", obs_v(), pk(2'b10, 1, 0, 0, 3'd1));
        send(8'b0000_0000, 4);

        // 3. two corrupted frames: flywheel then loss
        send(8'b0000_0000, 2); step(1, 1);
        chk("flywheel1", obs_v(), pk(2'b10, 1, 1, 0, 3'd0));
        send(8'b0000_0000, 5);
        send(8'b0000_0000, 2); step(1, 1);
        chk("loss", obs_v(), pk(2'b00, 0, 1, 0, 3'd0));
        step(0, 1);           chk("hunt_after",  obs_v(), pk(2'b00, 0, 0, 0, 3'd0));
        send(8'b0000_0000, 4);

        // 4. match off the check bit in VERIFY is ignored; missed check returns to HUNT
        send(8'b0000_0010, 2); step(1, 1);
        chk("t4_verify", obs_v(), pk(2'b01, 0, 0, 1, 3'd0));
        send(8'b0000_0010, 4); step(1, 1);
        chk("t4_hit_pos4", obs_v(), pk(2'b01, 0, 0, 1, 3'd5));
        send(8'b0000_0000, 2); step(0, 1);
        chk("t4_check_fail", obs_v(), pk(2'b00, 0, 0, 0, 3'd0));

        // 5. relock, then a 5-cycle bit_valid gap mid-frame
        send(8'b1010_0000, 8);
        send(8'b1010_0000, 8);
        send(8'b0000_0010, 2); step(1, 1);
        chk("relock", obs_v(), pk(2'b10, 1, 0, 1, 3'd0));
        send(8'b0000_0000, 2);
        chk("pre_pause", obs_v(), pk(2'b10, 1, 0, 0, 3'd2));
        for (int i = 0; i < 5; i++) begin
            step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
            chk("pause", obs_v(), pk(2'b10, 1, 0, 0, 3'd2));
        end
        send(8'b0000_0000, 3);
        send(8'b0000_0010, 2);
        chk("pre_check", obs_v(), pk(2'b10, 1, 0, 0, 3'd7));
        step(1, 1);
        chk("fs_on_sched", obs_v(), pk(2'b10, 1, 1, 1, 3'd0));

        // 6. reset while locked at bit_pos 6
        send(8'b0000_0000, 5); step(1, 1);
        chk("pre_rst", obs_v(), pk(2'b10, 1, 0, 0, 3'd6));
`ifdef FRAME_SYNC_STATS_EN
        chk("hits_pre_rst",   hit_count,  16'd6);
        chk("misses_pre_rst", miss_count, 16'd3);
`endif
        @(negedge clk);
        rst = 1'b1; bit_valid = 1'b1; x = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_locked", obs_v(), pk(2'b00, 0, 0, 0, 3'd0));
`ifdef FRAME_SYNC_STATS_EN
        chk("hits_rst",   hit_count,  16'd0);
        chk("misses_rst", miss_count, 16'd0);
`endif

        // overlapping patterns 10101: second match is on a non-check bit
        step(1, 1); step(0, 1); step(1, 1);
        chk("ovl_first", obs_v(), pk(2'b01, 0, 0, 1, 3'd0));
        step(0, 1);
        chk("ovl_gap", obs_v(), pk(2'b01, 0, 0, 0, 3'd1));
        step(1, 1);
        chk("ovl_second", obs_v(), pk(2'b01, 0, 0, 1, 3'd2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
